level_to_gain: RTL and testbench

Applies a user-set linear gain to the audio stream, taking the gain as four BCD digits in the same thousandths format the level display produces (0000–9999 = 0.000–9.999×). A sequential converter turns the digits into a Q-format coefficient by BCD accumulation and restoring division. A two-stage pipeline then multiplies, rounds and saturates each sample. The block sits in the channel strip ahead of the output-level meter, so a meter reading can be typed back in as a gain.

---
 rtl/level_to_gain.sv | 169 ++++++++++++++++
 tb/tb_level_to_gain.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_to_gain.sv
// level_to_gain: BCD gain entry converted to a Q-format coefficient,
// applied to the audio stream with rounding and saturation.
module level_to_gain #(
  parameter int FRAC_BITS = 10
) (
  input  logic               clk_48,
  input  logic               reset,
  input  logic [3:0]         num3,
  input  logic [3:0]         num2,
  input  logic [3:0]         num1,
  input  logic [3:0]         num0,
  input  logic               load,
  output logic               busy,
  output logic               err,
  input  logic               sample_valid,
  input  logic signed [15:0] inWave,
  output logic signed [15:0] outWave,
  output logic               out_valid,
  output logic               clip
);

  localparam int GW = FRAC_BITS + 4;
  localparam int DW = FRAC_BITS + 14;
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BCD    = 2'd1;
  localparam logic [1:0] S_DIV    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic signed [31:0] RND =
    32'sd1 <<< (FRAC_BITS - 1);

  logic [1:0]          state;
  logic [15:0]         dig;
  logic [13:0]         acc;
  logic [13:0]         acc_nxt;
  logic [CW-1:0]       cnt;
  logic [DW-1:0]       nsh;
  logic [DW-1:0]       n_init;
  logic [9:0]          rem;
  logic [10:0]         trial;
  logic                ge;
  logic [GW-1:0]       quo;
  logic [GW-1:0]       gain_q;
  logic                bad;

  logic                v1;
  logic signed [30:0]  p;
  logic signed [30:0]  a_ext;
  logic signed [30:0]  g_ext;
  logic signed [31:0]  pr;
  logic signed [31:0]  r;

  assign busy = (state != S_IDLE);

  // Digit check, BCD accumulate step and one restoring-division step
  always_comb begin
    bad = (num3 > 4'd9) || (num2 > 4'd9) ||
          (num1 > 4'd9) || (num0 > 4'd9);
    acc_nxt = acc * 14'd10 + {10'd0, dig[15:12]};
    n_init = (DW'(acc_nxt) << FRAC_BITS) + DW'(500);
    trial = {rem, nsh[DW-1]};
    ge = (trial >= 11'd1000);
  end

  // Conversion FSM: latch digits, accumulate, divide, commit gain
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state  <= S_IDLE;
      dig    <= '0;
      acc    <= '0;
      cnt    <= '0;
      nsh    <= '0;
      rem    <= '0;
      quo    <= '0;
      err    <= 1'b0;
      gain_q <= GW'(1) << FRAC_BITS;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (load) begin
            if (bad) begin
              err <= 1'b1;
            end else begin
              dig   <= {num3, num2, num1, num0};
              err   <= 1'b0;
              acc   <= '0;
              cnt   <= '0;
              state <= S_BCD;
            end
          end
        end
        S_BCD: begin
          acc <= acc_nxt;
          dig <= {dig[11:0], 4'd0};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(3)) begin
            nsh   <= n_init;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          nsh <= {nsh[DW-2:0], 1'b0};
          rem <= ge ? 10'(trial - 11'd1000)
                    : trial[9:0];
          quo <= {quo[GW-2:0], ge};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          gain_q <= quo;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand extension and rounding for the sample path
  always_comb begin
    a_ext = {{15{inWave[15]}}, inWave};
    g_ext = $signed({{(31 - GW){1'b0}}, gain_q});
    pr = $signed({p[30], p}) + RND;
    r = pr >>> FRAC_BITS;
  end

  // Stage 1: product of sample and current gain
  always_ff @(posedge clk_48) begin
    if (reset) begin
      v1 <= 1'b0;
      p  <= '0;
    end else begin
      v1 <= sample_valid;
      if (sample_valid) begin
        p <= a_ext * g_ext;
      end
    end
  end

  // Stage 2: round, saturate and flag clipping
  always_ff @(posedge clk_48) begin
    if (reset) begin
      out_valid <= 1'b0;
      outWave   <= '0;
      clip      <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        if (r > 32'sd32767) begin
          outWave <= 16'sd32767;
          clip    <= 1'b1;
        end else if (r < -32'sd32768) begin
          outWave <= -16'sd32768;
          clip    <= 1'b1;
        end else begin
          outWave <= r[15:0];
          clip    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_level_to_gain.sv
// tb_level_to_gain: table vectors, directed corner sequences and a
// random phase checked against a cycle-level behavioural model.
module tb_level_to_gain;

  logic clk_48 = 1'b0;
  logic reset = 1'b1;
  logic [3:0] num3 = '0;
  logic [3:0] num2 = '0;
  logic [3:0] num1 = '0;
  logic [3:0] num0 = '0;
  logic load = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [15:0] inWave = '0;
  logic busy;
  logic err;
  logic signed [15:0] outWave;
  logic out_valid;
  logic clip;

  level_to_gain dut (
    .clk_48(clk_48),
    .reset(reset),
    .num3(num3),
    .num2(num2),
    .num1(num1),
    .num0(num0),
    .load(load),
    .busy(busy),
    .err(err),
    .sample_valid(sample_valid),
    .inWave(inWave),
    .outWave(outWave),
    .out_valid(out_valid),
    .clip(clip)
  );

  always #5 clk_48 = ~clk_48;

  int nvec = 0;
  int nfail = 0;

  typedef struct {
    int cyc;
    int w;
    int c;
  } exp_t;

  typedef struct {
    logic [15:0] dig;
    int x;
    int w;
    int c;
    int g;
  } vec_t;

  exp_t q[$];
  vec_t tbl[12];
  int cyc = 0;
  int mgain = 1024;
  int pend = 0;
  int pgain = 0;
  int merr = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic signed [31:0] got,
                     input logic signed [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               nm, got, want, $time);
    end
  endtask

  function automatic int gain_of(input logic [15:0] d);
    int v;
    v = int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 +
        int'(d[7:4]) * 10 + int'(d[3:0]);
    return (v * 1024 + 500) / 1000;
  endfunction

  task automatic scale(input int x, input int g,
                       output int w, output int c);
    real rr;
    rr = $floor((real'(x) * real'(g) + 512.0) / 1024.0);
    if (rr > 32767.0) begin
      w = 32767; c = 1;
    end else if (rr < -32768.0) begin
      w = -32768; c = 1;
    end else begin
      w = int'(rr); c = 0;
    end
  endtask

  // Behavioural model: gain update 29 edges after acceptance
  always @(posedge clk_48) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
      mgain = 1024;
      pend = 0;
      merr = 0;
    end else begin
      if (sample_valid) begin
        scale(int'(inWave), mgain, e.w, e.c);
        e.cyc = cyc;
        q.push_back(e);
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) mgain = pgain;
      end else if (load) begin
        if (num3 > 9 || num2 > 9 || num1 > 9 || num0 > 9) begin
          merr = 1;
        end else begin
          merr = 0;
          pgain = gain_of({num3, num2, num1, num0});
          pend = 29;
        end
      end
    end
  end

  // Scoreboard: every output cycle compared with the model
  always @(negedge clk_48) begin
    bit ev;
    if (mon_en) begin
      ev = (q.size() > 0) && (q[0].cyc == cyc - 1);
      chk("out_valid", out_valid, ev);
      if (ev && out_valid) begin
        chk("outWave", outWave, q[0].w);
        chk("clip", clip, q[0].c);
      end
      if (ev) void'(q.pop_front());
      chk("busy", busy, pend > 0);
      chk("err", err, merr);
    end
  end

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d,
                         input int exp_busy,
                         input int exp_err);
    int n;
    {num3, num2, num1, num0} = d;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("err_at_load", err, exp_err);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, exp_busy);
  endtask

  task automatic apply(input string nm, input int x,
                       input int w, input int c);
    sample_valid = 1'b1;
    inWave = 16'(x);
    tick();
    sample_valid = 1'b0;
    tick();
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_wave"}, outWave, w);
    chk({nm, "_clip"}, clip, c);
  endtask

  initial begin
    tbl[0]  = '{16'h1000, 1000, 1000, 0, 1024};
    tbl[1]  = '{16'h1000, -32768, -32768, 0, 1024};
    tbl[2]  = '{16'h2500, 1000, 2500, 0, 2560};
    tbl[3]  = '{16'h2500, 20000, 32767, 1, 2560};
    tbl[4]  = '{16'h2500, -20000, -32768, 1, 2560};
    tbl[5]  = '{16'h0500, -3, -1, 0, 512};
    tbl[6]  = '{16'h0500, 3, 2, 0, 512};
    tbl[7]  = '{16'h0000, 12345, 0, 0, 0};
    tbl[8]  = '{16'h0000, -32768, 0, 0, 0};
    tbl[9]  = '{16'h9999, 3, 30, 0, 10239};
    tbl[10] = '{16'h9999, -4000, -32768, 1, 10239};
    tbl[11] = '{16'h0001, 32767, 32, 0, 1};

    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outWave", outWave, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gain", dut.gain_q, 1024);

    apply("unity", 1000, 1000, 0);

    for (int i = 0; i < 12; i++) begin
      do_load(tbl[i].dig, 29, 0);
      chk("tbl_gain", dut.gain_q, tbl[i].g);
      apply("tbl", tbl[i].x, tbl[i].w, tbl[i].c);
    end

    do_load(16'h2500, 29, 0);
    do_load(16'h25C0, 0, 1);
    chk("bad_gain", dut.gain_q, 2560);
    apply("bad_keep", 1000, 2500, 0);
    do_load(16'h1000, 29, 0);
    apply("bad_recover", 1000, 1000, 0);

    sample_valid = 1'b1;
    inWave = 16'sd1000;
    {num3, num2, num1, num0} = 16'h2500;
    load = 1'b1;
    tick();
    load = 1'b0;
    {num3, num2, num1, num0} = 16'h9999;
    for (int j = 1; j <= 28; j++) begin
      load = (j >= 5 && j <= 20);
      tick();
    end
    load = 1'b0;
    tick();
    tick();
    chk("commit_old", outWave, 1000);
    tick();
    chk("commit_new", outWave, 2500);
    sample_valid = 1'b0;
    chk("commit_gain", dut.gain_q, 2560);
    tick();

    {num3, num2, num1, num0} = 16'h9999;
    load = 1'b1;
    tick();
    load = 1'b0;
    sample_valid = 1'b1;
    inWave = 16'sd5;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_gain", dut.gain_q, 1024);
    tick();
    do_load(16'h9999, 29, 0);
    chk("max_gain", dut.gain_q, 10239);
    apply("max", 3, 30, 0);

    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      inWave = 16'($urandom);
      load = ($urandom_range(0, 29) == 0);
      num3 = 4'($urandom_range(0, 9));
      num2 = 4'($urandom_range(0, 9));
      num1 = 4'($urandom_range(0, 9));
      num0 = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0)
        num2 = 4'($urandom_range(10, 15));
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    sample_valid = 1'b0;
    load = 1'b0;
    reset = 1'b0;
    repeat (40) tick();
    chk("final_gain", dut.gain_q, mgain);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
